seq_divider: RTL and testbench
==============================

# seq_divider

Sequential shift-subtract (restoring) divider, the inverse companion to the team's Booth multiplier. It takes a dividend and divisor on a start pulse and iterates one quotient bit per clock. It returns quotient, remainder and a divide-by-zero flag with a one-cycle done pulse. It sits beside the multiplier in the arithmetic unit, under the same start/done handshake.

## Interface
- WIDTH, 16, operand/result width in bits (≥2)
- clk  input  1  clock, all state updates on rising edge
- clr  input  1  reset; synchronous, active-high
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  numerator; captured on the accepting edge
- divisor  input  WIDTH  denominator; captured on the accepting edge
- busy  output  1  high from the cycle after acceptance through the DONE cycle
- done  output  1  one-cycle pulse; results valid
- quotient  output  WIDTH  result, held until next acceptance
- remainder  output  WIDTH  result, held until next acceptance
- div_by_zero  output  1  set with done when divisor was 0; held with results

## Operation
- States are IDLE → LOAD → ITER → FIX → DONE → IDLE.
- IDLE: if start=1 at an edge, latch the operands and go to LOAD. Otherwise stay.
- LOAD:
  - If divisor==0, go to DONE with quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
  - Else: partial remainder R (WIDTH+1 bits)=0; Q=|dividend|; D=|divisor|; iteration counter=WIDTH; clear div_by_zero; go to ITER.
- ITER, once per cycle:
  - R'={R[WIDTH-1:0],Q[WIDTH-1]}; T=R'−{0,D}.
  - If T[WIDTH]==0 (non-negative): R=T, Q={Q[WIDTH-2:0],1}.
  - Else: R=R', Q={Q[WIDTH-2:0],0}.
  - Decrement the counter. Leave for FIX on the iteration where the counter goes 1→0.
- FIX: apply the sign correction (see Configuration) and register quotient and remainder. Go to DONE.
- DONE: done=1 for exactly this cycle. Next state is IDLE.
- start while not in IDLE is ignored. It is not queued.
- Arithmetic is modulo 2^WIDTH. Signed −2^(WIDTH−1)/−1 wraps to quotient=0x8000 with remainder=0 and no error flag.
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, state=IDLE.
- clr in any state aborts the operation. The next cycle is IDLE with all outputs at reset values, and no done is produced. clr wins over a simultaneous start.

## Timing
- The edge that samples start is E0. State is LOAD for the cycle after E0, ITER for the next WIDTH cycles, then FIX, then DONE.
- Normal operation: done is high in cycle WIDTH+3 after E0 (cycle 19 for WIDTH=16).
- Divide by zero: done is high in cycle 2 after E0.
- Results change only at the FIX→DONE edge, or the LOAD→DONE edge on divide by zero. They are stable while done=1 and remain stable afterwards.
- A new start is accepted at the earliest in the IDLE cycle after DONE, so back-to-back throughput is WIDTH+4 cycles.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- Macro: DIV_SIGNED_EN.
- Defined:
  - Operands are two's complement.
  - LOAD takes magnitudes.
  - FIX negates the quotient if the operand signs differ and negates the remainder if the dividend is negative. The quotient truncates toward zero and the remainder takes the sign of the dividend.
- Undefined:
  - Operands are unsigned.
  - LOAD uses them as-is and FIX passes Q and R[WIDTH-1:0] straight through.
  - No sign logic is synthesised.

## Structure
- Package div_pkg holds:
  - the state enum (IDLE, LOAD, ITER, FIX, DONE)
  - the default width constant (16)
  - the counter width constant, clog2(WIDTH)+1
- One sub-module, div_controller, holds the FSM and iteration counter. It drives load/shift/fix strobes to the datapath (R, Q, D registers and the subtractor) in seq_divider. This mirrors the multiplier's datapath/controller split.

## Test plan
- Unsigned: 100/7 → quotient=14, remainder=2, div_by_zero=0, done at cycle 19 after E0, busy high cycles 1–19.
- Divide by zero: 7/0 → done at cycle 2 with quotient=0xFFFF, remainder=7, div_by_zero=1. A following 9/3 gives quotient=3, remainder=0, div_by_zero=0.
- Signed (DIV_SIGNED_EN): −100/7 → quotient=0xFFF2 (−14), remainder=0xFFFE (−2). 100/−7 → quotient=0xFFF2, remainder=2. −32768/−1 → quotient=0x8000, remainder=0.
- Unsigned boundary: 0xFFFF/1 → quotient=0xFFFF, remainder=0. 5/9 → quotient=0, remainder=5.
- Reset mid-op: clr at cycle 10 after E0 → no done pulse, all outputs 0 next cycle. A fresh 50/5 then yields quotient=10, remainder=0 on schedule.
- Start while busy: pulse start with 1/1 at cycle 5 of 100/7 → ignored. 100/7 result is unchanged and only one done pulse occurs.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants for the sequential restoring divider: state encoding and widths.
// The signed build is selected by defining DIV_SIGNED_EN.
package div_pkg;

    localparam int DIV_WIDTH = 16;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

    typedef logic [2:0] div_state_t;

    localparam div_state_t S_IDLE = 3'd0;
    localparam div_state_t S_LOAD = 3'd1;
    localparam div_state_t S_ITER = 3'd2;
    localparam div_state_t S_FIX  = 3'd3;
    localparam div_state_t S_DONE = 3'd4;

    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/div_controller.sv
// FSM and iteration counter for seq_divider; issues load/shift/fix strobes to the datapath.
// Identical in signed (DIV_SIGNED_EN) and unsigned builds.
module div_controller
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic clk,
    input  logic clr,
    input  logic start,
    input  logic divisor_zero,
    output logic accept,
    output logic load,
    output logic zero_load,
    output logic shift,
    output logic fix,
    output logic busy,
    output logic done
);

    localparam int CNT_W = cnt_width(WIDTH);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) state <= S_LOAD;
                S_LOAD: begin
                    if (divisor_zero) begin
                        state <= S_DONE;
                    end else begin
                        cnt   <= CNT_W'(WIDTH);
                        state <= S_ITER;
                    end
                end
                S_ITER: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= S_FIX;
                end
                S_FIX:   state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes are decoded from registered state; only accept looks at start.
    assign accept    = (state == S_IDLE) && start;
    assign load      = (state == S_LOAD) && !divisor_zero;
    assign zero_load = (state == S_LOAD) && divisor_zero;
    assign shift     = (state == S_ITER);
    assign fix       = (state == S_FIX);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

endmodule

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock, start/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands; default build is unsigned.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    logic             accept, load, zero_load, shift, fix;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [WIDTH-1:0] r, q, d;
    logic [WIDTH:0]   r_shift, trial;
    logic [WIDTH-1:0] r_next, q_next;
    logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;

    div_controller #(.WIDTH(WIDTH)) u_ctrl (
        .clk          (clk),
        .clr          (clr),
        .start        (start),
        .divisor_zero (b_reg == '0),
        .accept       (accept),
        .load         (load),
        .zero_load    (zero_load),
        .shift        (shift),
        .fix          (fix),
        .busy         (busy),
        .done         (done)
    );

    // A settled remainder is always below D, so only the shifted trial value needs the extra bit.
    assign r_shift = {r, q[WIDTH-1]};
    assign trial   = r_shift - {1'b0, d};
    assign r_next  = trial[WIDTH] ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
    assign q_next  = {q[WIDTH-2:0], ~trial[WIDTH]};

`ifdef DIV_SIGNED_EN
    logic a_neg, b_neg;
    assign a_neg = a_reg[WIDTH-1];
    assign b_neg = b_reg[WIDTH-1];
    assign a_mag = a_neg ? -a_reg : a_reg;
    assign b_mag = b_neg ? -b_reg : b_reg;
    assign q_fix = (a_neg ^ b_neg) ? -q : q;
    assign r_fix = a_neg ? -r : r;
`else
    assign a_mag = a_reg;
    assign b_mag = b_reg;
    assign q_fix = q;
    assign r_fix = r;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            a_reg       <= '0;
            b_reg       <= '0;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (accept) begin
                a_reg <= dividend;
                b_reg <= divisor;
            end
            if (zero_load) begin
                quotient    <= '1;
                remainder   <= a_reg;
                div_by_zero <= 1'b1;
            end
            if (load) begin
                r           <= '0;
                q           <= a_mag;
                d           <= b_mag;
                div_by_zero <= 1'b0;
            end
            if (shift) begin
                r <= r_next;
                q <= q_next;
            end
            if (fix) begin
                quotient  <= q_fix;
                remainder <= r_fix;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table plus hand-written corner sequences,
// with a scoreboard queue consumed on every done pulse.
module tb_seq_divider;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         clr;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           e0;
        int           lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   checks     = 0;
    int   failures   = 0;
    int   cyc        = 0;
    int   done_count = 0;
    int   ops        = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            done_count++;
            if (sb.size() == 0) begin
                check_output("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check_output("quotient", {16'd0, quotient}, {16'd0, e.q});
                check_output("remainder", {16'd0, remainder}, {16'd0, e.r});
                check_output("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.z});
                check_output("done_cycle", cyc - e.e0 + 1, e.lat);
            end
        end
    end

    task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] q, input logic [W-1:0] r,
                                  input logic z, input int inject);
        int  lat;
        int  k;
        bit  seen;
        lat = (b == '0) ? 2 : W + 3;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back('{q: q, r: r, z: z, e0: cyc + 1, lat: lat});
        ops++;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k     = 1;
        seen  = 1'b0;
        while (k <= lat + 5 && !seen) begin
            if (k <= lat) check_output("busy_during_op", {31'd0, busy}, 32'd1);
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (inject != 0 && k == inject) begin
                    start    = 1'b1;
                    dividend = 16'd1;
                    divisor  = 16'd1;
                end
                if (inject != 0 && k == inject + 1) start = 1'b0;
                @(negedge clk);
                k++;
            end
        end
        if (!seen) check_output("done_timeout", 32'd0, 32'd1);
        start = 1'b0;
        @(negedge clk);
        check_output("done_width", {31'd0, done}, 32'd0);
        check_output("busy_after", {31'd0, busy}, 32'd0);
        check_output("quotient_held", {16'd0, quotient}, {16'd0, q});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clr      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check_output("reset_busy", {31'd0, busy}, 32'd0);
        check_output("reset_done", {31'd0, done}, 32'd0);
        check_output("reset_quotient", {16'd0, quotient}, 32'd0);
        check_output("reset_remainder", {16'd0, remainder}, 32'd0);
        check_output("reset_dbz", {31'd0, div_by_zero}, 32'd0);
        clr = 1'b0;

`ifdef DIV_SIGNED_EN
        vecs.push_back('{a: 16'hFF9C, b: 16'd7,    q: 16'hFFF2, r: 16'hFFFE, z: 1'b0});
        vecs.push_back('{a: 16'd100,  b: 16'hFFF9, q: 16'hFFF2, r: 16'd2,    z: 1'b0});
        vecs.push_back('{a: 16'h8000, b: 16'hFFFF, q: 16'h8000, r: 16'd0,    z: 1'b0});
        vecs.push_back('{a: 16'd7,    b: 16'd0,    q: 16'hFFFF, r: 16'd7,    z: 1'b1});
        vecs.push_back('{a: 16'hFFF9, b: 16'd0,    q: 16'hFFFF, r: 16'hFFF9, z: 1'b1});
        vecs.push_back('{a: 16'd9,    b: 16'd3,    q: 16'd3,    r: 16'd0,    z: 1'b0});
        vecs.push_back('{a: 16'hFFF7, b: 16'hFFFD, q: 16'd3,    r: 16'd0,    z: 1'b0});
        vecs.push_back('{a: 16'd5,    b: 16'd9,    q: 16'd0,    r: 16'd5,    z: 1'b0});
        vecs.push_back('{a: 16'd100,  b: 16'd7,    q: 16'd14,   r: 16'd2,    z: 1'b0});
`else
        vecs.push_back('{a: 16'd100,  b: 16'd7,    q: 16'd14,   r: 16'd2,    z: 1'b0});
        vecs.push_back('{a: 16'd7,    b: 16'd0,    q: 16'hFFFF, r: 16'd7,    z: 1'b1});
        vecs.push_back('{a: 16'd9,    b: 16'd3,    q: 16'd3,    r: 16'd0,    z: 1'b0});
        vecs.push_back('{a: 16'hFFFF, b: 16'd1,    q: 16'hFFFF, r: 16'd0,    z: 1'b0});
        vecs.push_back('{a: 16'd5,    b: 16'd9,    q: 16'd0,    r: 16'd5,    z: 1'b0});
        vecs.push_back('{a: 16'd0,    b: 16'd5,    q: 16'd0,    r: 16'd0,    z: 1'b0});
        vecs.push_back('{a: 16'hFFFF, b: 16'hFFFF, q: 16'd1,    r: 16'd0,    z: 1'b0});
        vecs.push_back('{a: 16'h8000, b: 16'hFFFF, q: 16'd0,    r: 16'h8000, z: 1'b0});
        vecs.push_back('{a: 16'd1234, b: 16'd0,    q: 16'hFFFF, r: 16'd1234, z: 1'b1});
        vecs.push_back('{a: 16'hABCD, b: 16'h0010, q: 16'h0ABC, r: 16'h000D, z: 1'b0});
`endif

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, 0);
        end

        $display("[TB] start while busy");
        apply_stimulus(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 5);
        repeat (25) @(negedge clk);

        $display("[TB] clear mid-operation");
        dividend = 16'd100;
        divisor  = 16'd7;
        start    = 1'b1;
        sb.push_back('{q: 16'd14, r: 16'd2, z: 1'b0, e0: cyc + 1, lat: W + 3});
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sb.delete();
        check_output("abort_busy", {31'd0, busy}, 32'd0);
        check_output("abort_done", {31'd0, done}, 32'd0);
        check_output("abort_quotient", {16'd0, quotient}, 32'd0);
        check_output("abort_remainder", {16'd0, remainder}, 32'd0);
        check_output("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        clr = 1'b0;
        repeat (25) @(negedge clk);
        check_output("abort_idle", {31'd0, busy}, 32'd0);
        apply_stimulus(16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 0);

        $display("[TB] clear beats start");
        @(negedge clk);
        clr      = 1'b1;
        start    = 1'b1;
        dividend = 16'd3;
        divisor  = 16'd1;
        @(posedge clk);
        @(negedge clk);
        clr   = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_output("clr_over_start", {31'd0, busy}, 32'd0);
        repeat (25) @(negedge clk);

        check_output("scoreboard_empty", sb.size(), 32'd0);
        check_output("done_count", done_count, ops);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
